// File: rtl/vslc_spi_pkg.sv
// Shared opcodes, state encodings and command decode for the VSLC SPI target.
package vslc_spi_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_RDSR  = 8'h05;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_ADDR_RD = 3'd2;
   localparam logic [2:0] ST_ADDR_WR = 3'd3;
   localparam logic [2:0] ST_DATA_RD = 3'd4;
   localparam logic [2:0] ST_DATA_WR = 3'd5;
   localparam logic [2:0] ST_STATUS  = 3'd6;
   localparam logic [2:0] ST_IGNORE  = 3'd7;

   // Maps a received command byte to the state that serves it.
   function automatic logic [2:0] decode_cmd(input logic [7:0] op);
      logic [2:0] nxt;
      case (op)
         CMD_READ:  nxt = ST_ADDR_RD;
         CMD_WRITE: nxt = ST_ADDR_WR;
         CMD_RDSR:  nxt = ST_STATUS;
         default:   nxt = ST_IGNORE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/vslc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with one-clk rise/fall pulses
// derived from the synchronized level.
module vslc_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/vslc_spi_target.sv
// SPI mode-0 target serving READ/WRITE/RDSR against the core's byte-addressed
// storage, oversampled from the system clock.
module vslc_spi_target
   import vslc_spi_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   input  logic [7:0]        status_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              addr_strobe,
   output logic              busy
);

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_level_unused, cs_rise, cs_fall;
   logic mosi_s, mosi_unused_rise, mosi_unused_fall;

   vslc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst_n(rst_n), .din(spi_sck),
      .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
   );

   vslc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
      .q(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
   );

   vslc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din(spi_mosi),
      .q(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
   );

   logic [2:0]        state;
   logic [2:0]        bit_cnt;
   logic [7:0]        rx;
   logic [7:0]        tx;
   logic [7:0]        rd_capture;
   logic [ADDR_W-1:0] addr;
   logic              load_pending;
   logic [7:0]        rx_next;
   logic              byte_done;

   assign rx_next   = {rx[6:0], mosi_s};
   assign byte_done = (state != ST_IDLE) && sck_rise && (bit_cnt == 3'd7);

   // A completed byte is acted on before a coincident CS rise returns the FSM
   // to IDLE, so a final write that lands with deselect is still committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= 3'd0;
         rx           <= 8'h00;
         tx           <= 8'h00;
         rd_capture   <= 8'h00;
         addr         <= '0;
         load_pending <= 1'b0;
         spi_miso_oe  <= 1'b0;
         rd_addr      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= 8'h00;
         addr_strobe  <= 1'b0;
      end else begin
         wr_en       <= 1'b0;
         addr_strobe <= 1'b0;
         rd_capture  <= rd_data;

         if (state == ST_IDLE) begin
            bit_cnt      <= 3'd0;
            load_pending <= 1'b0;
            if (cs_fall) begin
               state <= ST_CMD;
            end
         end else begin
            if (sck_rise) begin
               rx      <= rx_next;
               bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
               load_pending <= 1'b1;
               case (state)
                  ST_CMD: state <= decode_cmd(rx_next);
                  ST_ADDR_RD, ST_ADDR_WR: begin
                     addr        <= rx_next[ADDR_W-1:0];
                     rd_addr     <= rx_next[ADDR_W-1:0];
                     addr_strobe <= 1'b1;
                     state       <= (state == ST_ADDR_RD) ? ST_DATA_RD : ST_DATA_WR;
                  end
                  ST_DATA_RD: begin
                     addr    <= addr + ADDR_W'(1);
                     rd_addr <= addr + ADDR_W'(1);
                  end
                  ST_DATA_WR: begin
                     wr_en   <= 1'b1;
                     wr_addr <= addr;
                     wr_data <= rx_next;
                     addr    <= addr + ADDR_W'(1);
                  end
                  default: ;
               endcase
            end

            // tx only ever holds non-zero data in the two states that answer
            // the host, so shifting zeros keeps MISO low everywhere else.
            if (sck_fall) begin
               load_pending <= 1'b0;
               if (load_pending && state == ST_DATA_RD) begin
                  tx          <= rd_capture;
                  spi_miso_oe <= 1'b1;
               end else if (load_pending && state == ST_STATUS) begin
                  tx          <= status_in;
                  spi_miso_oe <= 1'b1;
               end else begin
                  tx <= {tx[6:0], 1'b0};
               end
            end

            if (cs_rise) begin
               state        <= ST_IDLE;
               bit_cnt      <= 3'd0;
               tx           <= 8'h00;
               spi_miso_oe  <= 1'b0;
               load_pending <= 1'b0;
            end
         end
      end
   end

   assign spi_miso = tx[7];
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_vslc_spi_target.sv
// Scoreboard bench for vslc_spi_target: a host driver pushes expected writes,
// strobes, rd_addr values and MISO bytes; independent monitors pop and compare.
module tb_vslc_spi_target;

   localparam int ADDR_W      = 8;
   localparam int SYNC_STAGES = 2;

   typedef struct packed {
      logic       chk_data;
      logic [7:0] data;
      logic       chk_oe;
      logic       oe;
   } miso_exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              spi_cs_n;
   logic              spi_sck;
   logic              spi_mosi;
   logic              spi_miso;
   logic              spi_miso_oe;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data = 8'h00;
   logic [7:0]        status_in;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              addr_strobe;
   logic              busy;

   int checks = 0;
   int errors = 0;

   miso_exp_t   miso_q[$];
   logic [15:0] wr_q[$];
   logic [7:0]  strobe_q[$];
   logic [7:0]  rdaddr_q[$];

   logic        mon_en = 1'b0;
   logic [7:0]  prev_rd = 8'h00;

   vslc_spi_target #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rd_addr(rd_addr), .rd_data(rd_data), .status_in(status_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .addr_strobe(addr_strobe), .busy(busy)
   );

   always #5 clk = ~clk;

   // Core storage model: each location holds the inverse of its address.
   always @(posedge clk) rd_data <= ~rd_addr;

   initial begin
      #300us;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic miso_exp_t mk(input logic cd, input logic [7:0] d, input logic co, input logic o);
      miso_exp_t e;
      e.chk_data = cd;
      e.data     = d;
      e.chk_oe   = co;
      e.oe       = o;
      return e;
   endfunction

   task automatic waitClks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spiBits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi = b[i];
         waitClks(5);
         spi_sck = 1'b1;
         waitClks(5);
         spi_sck = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input miso_exp_t e);
      miso_q.push_back(e);
      spiBits(b, 8);
   endtask

   task automatic csSelect();
      spi_cs_n = 1'b0;
      waitClks(5);
   endtask

   task automatic csRelease();
      waitClks(5);
      spi_cs_n = 1'b1;
      waitClks(10);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_miso"}, 32'(spi_miso), 32'd0);
      checkOutput({tag, "_miso_oe"}, 32'(spi_miso_oe), 32'd0);
      checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      checkOutput({tag, "_addr_strobe"}, 32'(addr_strobe), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Host-side MISO capture: a partial byte is dropped when CS rises.
   int         m_bits = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_oe_all = 1'b1;
   logic       m_oe_any = 1'b0;
   miso_exp_t  m_exp;

   always @(posedge spi_sck or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         m_bits   = 0;
         m_oe_all = 1'b1;
         m_oe_any = 1'b0;
      end else begin
         m_byte   = {m_byte[6:0], spi_miso};
         m_oe_all = m_oe_all & spi_miso_oe;
         m_oe_any = m_oe_any | spi_miso_oe;
         m_bits++;
         if (m_bits == 8) begin
            if (miso_q.size() == 0) begin
               checkOutput("miso_byte_expected", 32'(m_bits), 32'd0);
            end else begin
               m_exp = miso_q.pop_front();
               if (m_exp.chk_data) checkOutput("miso_byte", 32'(m_byte), 32'(m_exp.data));
               if (m_exp.chk_oe) checkOutput("miso_oe", 32'(m_exp.oe ? m_oe_all : m_oe_any), 32'(m_exp.oe));
            end
            m_bits   = 0;
            m_oe_all = 1'b1;
            m_oe_any = 1'b0;
         end
      end
   end

   // Core-side monitor for write strobes, address strobes and rd_addr motion.
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_en) begin
            checkOutput("wr_en_with_addr_strobe", 32'(addr_strobe), 32'd0);
            if (wr_q.size() == 0) checkOutput("wr_en_expected", 32'(wr_en), 32'd0);
            else checkOutput("wr_addr_data", 32'({wr_addr, wr_data}), 32'(wr_q.pop_front()));
         end
         if (addr_strobe) begin
            if (strobe_q.size() == 0) checkOutput("addr_strobe_expected", 32'(addr_strobe), 32'd0);
            else checkOutput("addr_strobe_rd_addr", 32'(rd_addr), 32'(strobe_q.pop_front()));
         end
         if (rd_addr != prev_rd) begin
            if (rdaddr_q.size() == 0) checkOutput("rd_addr_change", 32'(rd_addr), 32'(prev_rd));
            else checkOutput("rd_addr_seq", 32'(rd_addr), 32'(rdaddr_q.pop_front()));
            prev_rd = rd_addr;
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      spi_cs_n  = 1'b1;
      spi_sck   = 1'b0;
      spi_mosi  = 1'b0;
      status_in = 8'h3C;
      waitClks(3);
      checkResetValues("reset");
      rst_n = 1'b1;
      waitClks(3);
      prev_rd = rd_addr;
      mon_en  = 1'b1;

      $display("[TB] write burst at 0x10");
      strobe_q.push_back(8'h10);
      rdaddr_q.push_back(8'h10);
      wr_q.push_back(16'h10A5);
      wr_q.push_back(16'h115A);
      csSelect();
      applyStimulus(8'h02, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h10, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'hA5, mk(1'b0, 8'h00, 1'b0, 1'b0));
      applyStimulus(8'h5A, mk(1'b0, 8'h00, 1'b0, 1'b0));
      csRelease();
      checkOutput("write_busy_idle", 32'(busy), 32'd0);

      $display("[TB] read burst wrapping at 0xFF");
      strobe_q.push_back(8'hFF);
      rdaddr_q.push_back(8'hFF);
      rdaddr_q.push_back(8'h00);
      rdaddr_q.push_back(8'h01);
      csSelect();
      applyStimulus(8'h03, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'hFF, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h00, mk(1'b1, 8'h00, 1'b1, 1'b1));
      applyStimulus(8'h00, mk(1'b1, 8'hFF, 1'b1, 1'b1));
      csRelease();
      checkOutput("read_oe_after_cs", 32'(spi_miso_oe), 32'd0);
      checkOutput("read_miso_after_cs", 32'(spi_miso), 32'd0);

      $display("[TB] status read");
      csSelect();
      applyStimulus(8'h05, mk(1'b0, 8'h00, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++) applyStimulus(8'h00, mk(1'b1, 8'h3C, 1'b1, 1'b1));
      csRelease();

      $display("[TB] aborted write");
      strobe_q.push_back(8'h20);
      rdaddr_q.push_back(8'h20);
      csSelect();
      applyStimulus(8'h02, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h20, mk(1'b0, 8'h00, 1'b1, 1'b0));
      spiBits(8'hF8, 5);
      waitClks(5);
      spi_cs_n = 1'b1;
      waitClks(SYNC_STAGES + 2);
      checkOutput("abort_busy_fall", 32'(busy), 32'd0);
      waitClks(10);
      strobe_q.push_back(8'h30);
      rdaddr_q.push_back(8'h30);
      wr_q.push_back(16'h3077);
      csSelect();
      applyStimulus(8'h02, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h30, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h77, mk(1'b0, 8'h00, 1'b0, 1'b0));
      csRelease();

      $display("[TB] unknown opcode");
      csSelect();
      applyStimulus(8'h9F, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h02, mk(1'b1, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'hFF, mk(1'b1, 8'h00, 1'b1, 1'b0));
      csRelease();

      $display("[TB] reset during read data");
      strobe_q.push_back(8'h40);
      rdaddr_q.push_back(8'h40);
      csSelect();
      applyStimulus(8'h03, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h40, mk(1'b0, 8'h00, 1'b1, 1'b0));
      spiBits(8'h00, 2);
      spi_mosi = 1'b0;
      waitClks(5);
      spi_sck = 1'b1;
      waitClks(2);
      rdaddr_q.push_back(8'h00);
      rst_n = 1'b0;
      #1;
      checkResetValues("midreset");
      waitClks(2);
      rst_n   = 1'b1;
      spi_sck = 1'b0;
      waitClks(3);
      spi_cs_n = 1'b1;
      waitClks(12);
      strobe_q.push_back(8'h00);
      rdaddr_q.push_back(8'h01);
      csSelect();
      applyStimulus(8'h03, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h00, mk(1'b0, 8'h00, 1'b1, 1'b0));
      applyStimulus(8'h00, mk(1'b1, 8'hFF, 1'b1, 1'b1));
      csRelease();

      waitClks(20);
      checkOutput("pending_writes", 32'(wr_q.size()), 32'd0);
      checkOutput("pending_strobes", 32'(strobe_q.size()), 32'd0);
      checkOutput("pending_rd_addr", 32'(rdaddr_q.size()), 32'd0);
      checkOutput("pending_miso", 32'(miso_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
